// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x WIDTH register array used as FIFO storage.
//   clk, rst   : clock, asynchronous active-high reset (clears every entry)
//   we         : write enable
//   waddr      : write address
//   wdata      : write data
//   raddr      : read address
//   rdata      : asynchronous read data, mem[raddr]
module fifo_mem #(
  parameter int WIDTH  = 38,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  // Show-ahead read: no register between storage and output.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fifo_sync.sv
// fifo_sync: single-clock first-word-fall-through FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   wr_en,din: write request / data (accepted when !full, or when popping)
//   rd_en    : read request, pops the head when !empty
//   dout     : head entry, valid whenever empty=0
//   empty, full, count : registered occupancy status
//   ovf, udf : registered one-cycle pulses for a dropped write / a read
//              while empty
module fifo_sync #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf,
  output logic                     udf
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc, rd_acc;

  // A write while full is still taken when the head is popped in the same
  // cycle: the slot being freed is the one overwritten, so order holds.
  assign wr_acc = wr_en & (~full_q | rd_en);
  assign rd_acc = rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    // Flags follow the next count so they change on the same edge.
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
    ovf_d   = wr_en & full_q & ~rd_en;
    udf_d   = rd_en & empty_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_acc),
    .waddr(wr_ptr_q),
    .wdata(din),
    .raddr(rd_ptr_q),
    .rdata(dout)
  );

  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_fifo_sync.sv
module tb_fifo_sync;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             empty, full, ovf, udf;
  logic [2:0]       count;

  int checks = 0;
  int failures = 0;

  logic [WIDTH-1:0] sb[$];
  int m_count = 0;

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .count(count),
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus; inputs are driven away from the edge.
  task automatic cyc(input logic w, input logic [WIDTH-1:0] d, input logic r);
    logic wacc, racc, e_ovf, e_udf;
    wr_en = w; din = d; rd_en = r;
    #1;
    wacc  = w && (m_count < DEPTH || r);
    racc  = r && (m_count > 0);
    e_ovf = w && (m_count == DEPTH) && !r;
    e_udf = r && (m_count == 0);
    if (racc) chk("pop_data", 32'(dout), 32'(sb.pop_front()));
    if (wacc) sb.push_back(d);
    m_count = m_count + (wacc ? 1 : 0) - (racc ? 1 : 0);
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(m_count));
    chk("empty", 32'(empty), 32'(m_count == 0));
    chk("full",  32'(full),  32'(m_count == DEPTH));
    chk("ovf",   32'(ovf),   32'(e_ovf));
    chk("udf",   32'(udf),   32'(e_udf));
    if (m_count > 0) chk("head", 32'(dout), 32'(sb[0]));
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    int pushed;
    logic [WIDTH-1:0] wd;
    // Reset then idle
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_dout",  32'(dout),  32'd0);
    chk("rst_ovf",   32'(ovf),   32'd0);
    chk("rst_udf",   32'(udf),   32'd0);
    @(posedge clk); #1;
    cyc(0, 8'h00, 0);

    // Fill, then drain in order
    cyc(1, 8'hA1, 0);
    cyc(1, 8'hA2, 0);
    cyc(1, 8'hA3, 0);
    cyc(1, 8'hA4, 0);
    chk("full_after_4", 32'(full), 32'd1);
    repeat (4) cyc(0, 8'h00, 1);
    chk("empty_after_drain", 32'(empty), 32'd1);

    // Overflow drop, then simultaneous write+read while full
    cyc(1, 8'hA1, 0);
    cyc(1, 8'hA2, 0);
    cyc(1, 8'hA3, 0);
    cyc(1, 8'hA4, 0);
    cyc(1, 8'hB5, 0);
    chk("ovf_pulse", 32'(ovf), 32'd1);
    cyc(0, 8'h00, 0);
    chk("ovf_clear", 32'(ovf), 32'd0);
    cyc(1, 8'hC6, 1);
    chk("full_stays", 32'(full), 32'd1);
    repeat (4) cyc(0, 8'h00, 1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // Empty with write+read, then read alone while empty
    cyc(1, 8'hD7, 1);
    chk("udf_wr_rd", 32'(udf), 32'd1);
    chk("dout_d7",   32'(dout), 32'hD7);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    chk("udf_rd_only", 32'(udf), 32'd1);
    chk("count_zero",  32'(count), 32'd0);
    cyc(0, 8'h00, 0);
    chk("udf_clear", 32'(udf), 32'd0);

    // Random interleaving across pointer wrap
    pushed = 0;
    for (int i = 0; i < 400 && (pushed < 10 || m_count > 0); i++) begin
      logic w, r;
      w  = (pushed < 10) && ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 2) != 0);
      wd = 8'(8'h10 + pushed);
      if (w && (m_count < DEPTH || (r && m_count > 0))) pushed++;
      cyc(w, wd, r);
    end
    chk("wrap_all_pushed", 32'(pushed), 32'd10);
    chk("wrap_drained",    32'(m_count), 32'd0);

    // Asynchronous reset mid-burst with three entries held
    cyc(1, 8'hE1, 0);
    cyc(1, 8'hE2, 0);
    cyc(1, 8'hE3, 0);
    chk("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_dout",  32'(dout),  32'd0);
    sb.delete();
    m_count = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    cyc(1, 8'hF8, 0);
    cyc(0, 8'h00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
Single-clock first-word-fall-through FIFO with independent writer and reader ports. It is the elastic counterpart of the fixed-latency delay line: data leaves when the consumer asks for it, not after a fixed cycle count. Used between the board-logic producer and the VGA draw pipeline, where consumer stalls make a fixed delay unusable. Provides full/empty/count status and single-cycle overflow/underflow error pulses.

Parameters:
WIDTH, 38, bit width of each data word
DEPTH, 4, number of storage entries; power of two, >= 2

Ports:
clk  input  1  posedge-active clock
rst  input  1  reset; asynchronous, active-high
wr_en  input  1  write request; accepted when !full or rd_en same cycle (see Behaviour)
din  input  WIDTH  write data, sampled on accepted write
rd_en  input  1  read request; pops head entry when !empty
dout  output  WIDTH  head entry (show-ahead); valid whenever empty=0
empty  output  1  no entries stored
full  output  1  count == DEPTH
count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
ovf  output  1  one-cycle pulse: write requested while full and not accepted
udf  output  1  one-cycle pulse: read requested while empty

Behaviour:
- Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, ovf=0, udf=0, all storage entries=0, so dout=0. Reset mid-operation discards all contents immediately, without waiting for a clock edge.
- Pointers are ADDR_W=$clog2(DEPTH) bits wide and wrap modulo DEPTH naturally. Full/empty come from a registered count, not from pointer comparison.
- Write accepted (wr_acc) = wr_en & (!full | rd_en). On wr_acc: mem[wr_ptr]<=din, wr_ptr<=wr_ptr+1.
- Read accepted (rd_acc) = rd_en & !empty. On rd_acc: rd_ptr<=rd_ptr+1.
- count next = count + wr_acc - rd_acc. empty/full are registered and updated in the same edge as count.
- dout = mem[rd_ptr], combinational from storage. A word written to an empty FIFO appears on dout and deasserts empty one cycle after the write edge. Read latency is zero; the next head appears after the rd_acc edge.
- Empty with wr_en & rd_en: the write is accepted, the read is ignored, udf=1, and count becomes 1.
- Full with wr_en & rd_en: both are accepted, count stays DEPTH, and full stays 1. The overwritten slot is the one being popped, so the ordering holds.
- Full with wr_en & !rd_en: the write is dropped, the contents are unchanged, and ovf pulses on the next cycle.
- ovf and udf are registered. Each is high for exactly one cycle per offending request cycle and holds no sticky state.
- Data order is strictly FIFO. No word is duplicated or lost except dropped overflow writes.

Decomposition:
- No shared package is needed; ADDR_W and CNT_W are local constants derived from DEPTH.
- One natural sub-module is fifo_mem, a DEPTH x WIDTH register array with write port and async read port, reset to 0. Pointer, count and flag logic stay in fifo_sync.

Test Plan:
- Reset then idle, WIDTH=8, DEPTH=4 -> empty=1, full=0, count=0, dout=8'h00, ovf=udf=0.
- Write 8'hA1,A2,A3,A4 on consecutive cycles -> count steps 1..4, full=1 after the 4th edge, dout=8'hA1 from the cycle after the first write. Then pop 4 -> dout A1,A2,A3,A4 in order, empty=1 after the last pop.
- While full, write 8'hB5 with rd_en=0 -> ovf high for one cycle, count=4, subsequent reads return A1..A4 (B5 absent).
- While full, wr_en=rd_en=1 with din=8'hC6 -> count stays 4, full stays 1, and after draining the order is A2,A3,A4,C6.
- When empty, wr_en=rd_en=1 with din=8'hD7 -> udf pulses, count=1, dout=8'hD7 next cycle. rd_en alone while empty -> udf pulse, count stays 0.
- Wrap and reset: push and pop 10 words with random interleaving; the scoreboard matches order across pointer wrap. Assert rst mid-burst with count=3 -> count=0, empty=1 and dout=0 asynchronously, before the next edge.
